// File: rtl/pc_gen_unit.sv
// Fetch-stage PC generator: registered fetch PC with trap/redirect/stall/sequential
// next-PC selection, redirect-target misalignment pulse and saturating redirect counter.
module pc_gen_unit #(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     INC          = 4,
    parameter int unsigned     ALIGN_BITS   = 2,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned     CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StallF,
    input  logic             PCSrcE,
    input  logic [XLEN-1:0]  PCTargetE,
    input  logic             TrapE,
    output logic [XLEN-1:0]  PCF,
    output logic [XLEN-1:0]  PCPlusIncF,
    output logic             MisalignF,
    output logic [CNT_W-1:0] RedirectCnt
);

    if (!(INC == 2 || INC == 4)) begin : g_bad_inc
        $error("pc_gen_unit: INC must be 2 or 4");
    end

    logic [XLEN-1:0]  pc_q, pc_d;
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_bumped;
    logic             target_misaligned;

    assign PCPlusIncF        = pc_q + XLEN'(INC);
    assign target_misaligned = |PCTargetE[ALIGN_BITS-1:0];
    // Counter sticks at all-ones instead of wrapping.
    assign cnt_bumped        = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        pc_d       = pc_q;
        misalign_d = 1'b0;
        cnt_d      = cnt_q;
        if (TrapE) begin
            pc_d  = TRAP_VECTOR;
            cnt_d = cnt_bumped;
        end else if (PCSrcE) begin
            cnt_d = cnt_bumped;
            if (target_misaligned) begin
                pc_d       = TRAP_VECTOR;
                misalign_d = 1'b1;
            end else begin
                pc_d = PCTargetE;
            end
        end else if (!StallF) begin
            pc_d = PCPlusIncF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_VECTOR;
            misalign_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            cnt_q      <= cnt_d;
        end
    end

    assign PCF         = pc_q;
    assign MisalignF   = misalign_q;
    assign RedirectCnt = cnt_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Bench for pc_gen_unit: three parameterisations driven with shared stimulus and
// checked against a behavioural next-PC model.
module tb_pc_gen_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        StallF, PCSrcE, TrapE;
    logic [31:0] PCTargetE;

    always #5 clk = ~clk;

    // instance 0: INC=4/ALIGN=2, 1: INC=2/ALIGN=1, 2: INC=4 with CNT_W=4
    logic [31:0] pc_a, pc_b, pc_c, inc_a, inc_b, inc_c;
    logic        mis_a, mis_b, mis_c;
    logic [15:0] cnt_a, cnt_b;
    logic [3:0]  cnt_c;

    pc_gen_unit dut_a (
        .clk(clk), .rst(rst), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .TrapE(TrapE), .PCF(pc_a), .PCPlusIncF(inc_a), .MisalignF(mis_a), .RedirectCnt(cnt_a)
    );

    pc_gen_unit #(.INC(2), .ALIGN_BITS(1)) dut_b (
        .clk(clk), .rst(rst), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .TrapE(TrapE), .PCF(pc_b), .PCPlusIncF(inc_b), .MisalignF(mis_b), .RedirectCnt(cnt_b)
    );

    pc_gen_unit #(.CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .TrapE(TrapE), .PCF(pc_c), .PCPlusIncF(inc_c), .MisalignF(mis_c), .RedirectCnt(cnt_c)
    );

    logic [31:0] pc_o [3];
    logic [31:0] inc_o[3];
    logic        mis_o[3];
    logic [15:0] cnt_o[3];
    assign pc_o[0] = pc_a;  assign pc_o[1] = pc_b;  assign pc_o[2] = pc_c;
    assign inc_o[0] = inc_a; assign inc_o[1] = inc_b; assign inc_o[2] = inc_c;
    assign mis_o[0] = mis_a; assign mis_o[1] = mis_b; assign mis_o[2] = mis_c;
    assign cnt_o[0] = cnt_a; assign cnt_o[1] = cnt_b; assign cnt_o[2] = {12'b0, cnt_c};

    // behavioural reference state per instance
    int unsigned m_step[3]  = '{4, 2, 4};
    int unsigned m_align[3] = '{4, 2, 4};
    int unsigned m_cmax[3]  = '{65535, 65535, 15};
    logic [31:0] m_pc[3];
    logic        m_mis[3];
    int unsigned m_cnt[3];

    int total = 0;
    int bad   = 0;

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_pc[k] = 32'h0; m_mis[k] = 1'b0; m_cnt[k] = 0;
        end
    endtask

    // Apply one cycle of inputs, advance the model, land 1 time unit after the edge.
    task automatic step(input logic t, input logic s, input logic st, input logic [31:0] tgt);
        TrapE = t; PCSrcE = s; StallF = st; PCTargetE = tgt;
        for (int k = 0; k < 3; k++) begin
            m_mis[k] = 1'b0;
            if (t || s) begin
                if (m_cnt[k] < m_cmax[k]) m_cnt[k] = m_cnt[k] + 1;
            end
            if (t) begin
                m_pc[k] = 32'h100;
            end else if (s) begin
                if ((tgt % m_align[k]) != 0) begin
                    m_pc[k] = 32'h100; m_mis[k] = 1'b1;
                end else begin
                    m_pc[k] = tgt;
                end
            end else if (!st) begin
                m_pc[k] = m_pc[k] + m_step[k];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; StallF = 0; PCSrcE = 0; TrapE = 0; PCTargetE = '0;
        model_reset();
        repeat (3) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) begin
                total++;
                if (pc_o[k] !== 32'h0 || mis_o[k] !== 1'b0 || cnt_o[k] !== 16'h0) begin
                    bad++;
                    $display("FAIL reset[%0d] pc=%h mis=%b cnt=%0d want pc=0 mis=0 cnt=0", k, pc_o[k], mis_o[k], cnt_o[k]);
                end
                total++;
                if (inc_o[k] !== m_step[k]) begin
                    bad++;
                    $display("FAIL reset_inc[%0d] got=%h want=%h", k, inc_o[k], m_step[k]);
                end
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 0, 32'h0);
            total++;
            if (pc_a !== 32'(4 * i) || inc_a !== 32'(4 * i + 4) || cnt_a !== 16'h0) begin
                bad++;
                $display("FAIL seq_a pc=%h inc=%h cnt=%0d want pc=%h inc=%h cnt=0", pc_a, inc_a, cnt_a, 4 * i, 4 * i + 4);
            end
            total++;
            if (pc_b !== 32'(2 * i) || inc_b !== 32'(2 * i + 2)) begin
                bad++;
                $display("FAIL seq_b pc=%h inc=%h want pc=%h inc=%h", pc_b, inc_b, 2 * i, 2 * i + 2);
            end
        end
    endtask

    task automatic test_stall_redirect();
        repeat (4) step(0, 0, 0, 32'h0);
        total++;
        if (pc_a !== 32'h20) begin
            bad++; $display("FAIL pre_stall got=%h want=%h", pc_a, 32'h20);
        end
        repeat (2) begin
            step(0, 0, 1, 32'h0);
            total++;
            if (pc_a !== 32'h20 || pc_b !== m_pc[1] || cnt_a !== 16'h0) begin
                bad++; $display("FAIL stall_hold pc_a=%h pc_b=%h cnt=%0d want %h %h 0", pc_a, pc_b, cnt_a, 32'h20, m_pc[1]);
            end
        end
        step(0, 1, 1, 32'h80);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (pc_o[k] !== 32'h80 || cnt_o[k] !== 16'd1 || mis_o[k] !== 1'b0) begin
                bad++; $display("FAIL stall_redirect[%0d] pc=%h cnt=%0d mis=%b want 80 1 0", k, pc_o[k], cnt_o[k], mis_o[k]);
            end
        end
    endtask

    task automatic test_misalign();
        step(0, 1, 0, 32'h42);
        total++;
        if (pc_a !== 32'h100 || mis_a !== 1'b1 || cnt_a !== 16'd2) begin
            bad++; $display("FAIL misalign_a pc=%h mis=%b cnt=%0d want 100 1 2", pc_a, mis_a, cnt_a);
        end
        total++;
        if (pc_b !== 32'h42 || mis_b !== 1'b0 || cnt_b !== 16'd2) begin
            bad++; $display("FAIL misalign_b pc=%h mis=%b cnt=%0d want 42 0 2", pc_b, mis_b, cnt_b);
        end
        step(0, 1, 0, 32'h43);
        total++;
        if (mis_a !== 1'b1 || mis_b !== 1'b1 || pc_b !== 32'h100) begin
            bad++; $display("FAIL misalign_b2b mis_a=%b mis_b=%b pc_b=%h want 1 1 100", mis_a, mis_b, pc_b);
        end
        step(0, 0, 0, 32'h0);
        total++;
        if (mis_a !== 1'b0 || mis_b !== 1'b0 || pc_a !== 32'h104 || cnt_a !== 16'd3) begin
            bad++; $display("FAIL misalign_clear mis=%b%b pc=%h cnt=%0d want 00 104 3", mis_a, mis_b, pc_a, cnt_a);
        end
    endtask

    task automatic test_trap_priority();
        step(1, 1, 1, 32'h43);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (pc_o[k] !== 32'h100 || mis_o[k] !== 1'b0 || cnt_o[k] !== 16'(m_cnt[k])) begin
                bad++; $display("FAIL trap_prio[%0d] pc=%h mis=%b cnt=%0d want 100 0 %0d", k, pc_o[k], mis_o[k], cnt_o[k], m_cnt[k]);
            end
        end
        total++;
        if (cnt_a !== 16'd4) begin
            bad++; $display("FAIL trap_cnt got=%0d want=4", cnt_a);
        end
    endtask

    task automatic test_wrap();
        step(0, 1, 0, 32'hFFFF_FFFC);
        total++;
        if (inc_a !== 32'h0 || inc_b !== 32'hFFFF_FFFE) begin
            bad++; $display("FAIL wrap_inc a=%h b=%h want 0 fffffffe", inc_a, inc_b);
        end
        step(0, 0, 0, 32'h0);
        total++;
        if (pc_a !== 32'h0 || pc_c !== 32'h0 || pc_b !== 32'hFFFF_FFFE || mis_a !== 1'b0) begin
            bad++; $display("FAIL wrap a=%h b=%h c=%h want 0 fffffffe 0", pc_a, pc_b, pc_c);
        end
        step(0, 0, 0, 32'h0);
        total++;
        if (pc_b !== 32'h0 || pc_a !== 32'h4) begin
            bad++; $display("FAIL wrap_b a=%h b=%h want 4 0", pc_a, pc_b);
        end
    endtask

    task automatic test_async_reset();
        step(0, 1, 0, 32'h42);
        step(0, 1, 0, 32'h200);
        total++;
        if (pc_a !== 32'h200 || cnt_a === 16'h0) begin
            bad++; $display("FAIL async_setup pc=%h cnt=%0d want 200 nonzero", pc_a, cnt_a);
        end
        PCSrcE = 1'b1; PCTargetE = 32'h303; StallF = 1'b1;
        step(0, 1, 0, 32'h303);
        PCSrcE = 1'b1; PCTargetE = 32'h300;
        #2 rst = 1'b1;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            total++;
            if (pc_o[k] !== 32'h0 || mis_o[k] !== 1'b0 || cnt_o[k] !== 16'h0) begin
                bad++; $display("FAIL async_rst[%0d] pc=%h mis=%b cnt=%0d want 0 0 0", k, pc_o[k], mis_o[k], cnt_o[k]);
            end
        end
        @(posedge clk); #1;
        total++;
        if (pc_a !== 32'h0 || cnt_a !== 16'h0) begin
            bad++; $display("FAIL async_hold pc=%h cnt=%0d want 0 0", pc_a, cnt_a);
        end
        rst = 1'b0; PCSrcE = 1'b0; StallF = 1'b0;
        step(0, 0, 0, 32'h0);
        total++;
        if (pc_a !== 32'h4 || pc_b !== 32'h2) begin
            bad++; $display("FAIL async_resume a=%h b=%h want 4 2", pc_a, pc_b);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            step(0, 1, ($urandom_range(0, 1) == 1), $urandom & 32'hFFFF_FFFC);
            total++;
            if (cnt_c !== 4'(m_cnt[2]) || pc_c !== m_pc[2]) begin
                bad++; $display("FAIL sat_step%0d cnt=%0d pc=%h want %0d %h", i, cnt_c, pc_c, m_cnt[2], m_pc[2]);
            end
        end
        total++;
        if (cnt_c !== 4'd15 || cnt_a !== 16'd20) begin
            bad++; $display("FAIL saturation c=%0d a=%0d want 15 20", cnt_c, cnt_a);
        end
        step(0, 0, 0, 32'h0);
        total++;
        if (cnt_c !== 4'd15) begin
            bad++; $display("FAIL sat_seq got=%0d want=15", cnt_c);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0), $urandom);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (pc_o[k] !== m_pc[k] || mis_o[k] !== m_mis[k] || cnt_o[k] !== 16'(m_cnt[k])
                    || inc_o[k] !== m_pc[k] + m_step[k]) begin
                    bad++;
                    $display("FAIL random%0d[%0d] pc=%h mis=%b cnt=%0d inc=%h want %h %b %0d %h",
                             i, k, pc_o[k], mis_o[k], cnt_o[k], inc_o[k],
                             m_pc[k], m_mis[k], m_cnt[k], m_pc[k] + m_step[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_redirect();
        test_misalign();
        test_trap_priority();
        test_wrap();
        test_async_reset();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
